// File: rtl/logisim_tick_generator_multi.sv
// rtl/logisim_tick_generator_multi.sv - multi-rate clock-enable tick generator
//
// Divides FPGAClock into a one-cycle FPGATick clock-enable strobe. There are three
// preset periods and one runtime-programmable period. The block has run/pause gating
// and a synchronous restart. FPGATick is a clock enable and must never be used as a clock.
//
// Optional feature macro: TICKGEN_TICK_COUNTER_EN (builds the TickCount tick counter).
//
// Ports:
//   FPGAClock   in   1          system clock, all state on posedge
//   FPGAReset   in   1          asynchronous active-high reset
//   Enable      in   1          1 = divider runs, 0 = counter holds and no ticks
//   SpeedSel    in   2          0/1/2 = preset periods, 3 = programmable period
//   LoadReload  in   1          strobe: programmable period <= ReloadIn
//   ReloadIn    in   NrOfBits   new programmable period
//   Restart     in   1          strobe: resynchronise divider, next enabled edge ticks
//   FPGATick    out  1          registered one-cycle tick strobe
//   TickCount   out  CountBits  free-running tick counter (0 when feature not built)

module logisim_tick_generator_multi #(
    parameter int          NrOfBits     = 24,
    parameter int unsigned ReloadValue0 = 3125000,
    parameter int unsigned ReloadValue1 = 781250,
    parameter int unsigned ReloadValue2 = 195312,
    parameter int          CountBits    = 16
) (
    input  logic                 FPGAClock,
    input  logic                 FPGAReset,
    input  logic                 Enable,
    input  logic [1:0]           SpeedSel,
    input  logic                 LoadReload,
    input  logic [NrOfBits-1:0]  ReloadIn,
    input  logic                 Restart,
    output logic                 FPGATick,
    output logic [CountBits-1:0] TickCount
);

    localparam logic [NrOfBits-1:0] RELOAD0 = ReloadValue0[NrOfBits-1:0];
    localparam logic [NrOfBits-1:0] RELOAD1 = ReloadValue1[NrOfBits-1:0];
    localparam logic [NrOfBits-1:0] RELOAD2 = ReloadValue2[NrOfBits-1:0];
    localparam logic [NrOfBits-1:0] ONE     = {{(NrOfBits-1){1'b0}}, 1'b1};

    logic [NrOfBits-1:0] count_reg;
    logic [NrOfBits-1:0] prog_reload;
    logic [NrOfBits-1:0] sel_reload;
    logic [NrOfBits-1:0] eff_reload;
    logic                terminal;

    // The running period is held entirely in count_reg. The selected reload is
    // only sampled at terminal count, so a SpeedSel or ProgReload change mid-period
    // cannot cause a short or long tick interval.
    always_comb begin
        sel_reload = RELOAD0;
        case (SpeedSel)
            2'd0:    sel_reload = RELOAD0;
            2'd1:    sel_reload = RELOAD1;
            2'd2:    sel_reload = RELOAD2;
            default: sel_reload = prog_reload;
        endcase
    end

    // Periods 0 and 1 both mean "tick every enabled cycle".
    assign eff_reload = (sel_reload == '0) ? ONE : sel_reload;
    assign terminal   = Enable && (count_reg == '0);

    // prog_reload is read through sel_reload before this edge writes it. A load
    // on a terminal-count cycle therefore reloads with the old programmed period.
    always_ff @(posedge FPGAClock or posedge FPGAReset) begin
        if (FPGAReset) begin
            count_reg   <= '0;
            FPGATick    <= 1'b0;
            prog_reload <= RELOAD0;
        end else begin
            if (LoadReload) begin
                prog_reload <= ReloadIn;
            end
            if (Restart) begin
                count_reg <= '0;
                FPGATick  <= 1'b0;
            end else if (terminal) begin
                count_reg <= eff_reload - ONE;
                FPGATick  <= 1'b1;
            end else if (Enable) begin
                count_reg <= count_reg - ONE;
                FPGATick  <= 1'b0;
            end else begin
                FPGATick  <= 1'b0;
            end
        end
    end

`ifdef TICKGEN_TICK_COUNTER_EN
    localparam logic [CountBits-1:0] CONE = {{(CountBits-1){1'b0}}, 1'b1};

    logic [CountBits-1:0] tick_count;

    // Increments exactly when FPGATick is loaded with 1 and wraps naturally.
    always_ff @(posedge FPGAClock or posedge FPGAReset) begin
        if (FPGAReset) begin
            tick_count <= '0;
        end else if (Restart) begin
            tick_count <= '0;
        end else if (terminal) begin
            tick_count <= tick_count + CONE;
        end
    end

    assign TickCount = tick_count;
`else
    assign TickCount = '0;
`endif

endmodule
